// File: rtl/addc_pkg.sv
// Shared types for the limb-serial add/subtract sequencer.
package addc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } addc_state_e;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } addc_op_e;

endpackage

// File: rtl/addc_seq_addcpred.sv
// Carry-select adder: operands are cut into THRES-bit chunks, each chunk precomputes
// its sum for both carry-in values, and the real carry only drives a mux chain.
module addcpred #(
    parameter int WIDTH = 256,
    parameter int THRES = 80
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] o,
    output logic             cout
);

    localparam int CW  = (WIDTH <= THRES || THRES < 1) ? WIDTH : THRES;
    localparam int NCH = (WIDTH + CW - 1) / CW;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            localparam int LO  = gi * CW;
            localparam int CWI = (WIDTH - LO < CW) ? (WIDTH - LO) : CW;

            logic [CWI:0] sum0;
            logic [CWI:0] sum1;
            logic         c_in;
            logic         c_out;

            if (gi == 0) begin : g_first
                assign c_in = cin;
            end else begin : g_rest
                assign c_in = g_chunk[gi-1].c_out;
            end

            assign sum0 = {1'b0, a[LO +: CWI]} + {1'b0, b[LO +: CWI]};
            assign sum1 = {1'b0, a[LO +: CWI]} + {1'b0, b[LO +: CWI]} + {{CWI{1'b0}}, 1'b1};

            assign o[LO +: CWI] = c_in ? sum1[CWI-1:0] : sum0[CWI-1:0];
            assign c_out        = c_in ? sum1[CWI]     : sum0[CWI];
        end
    endgenerate

    assign cout = g_chunk[NCH-1].c_out;

endmodule

// File: rtl/addc_seq.sv
// Limb-serial wide add/subtract: one addcpred per limb, carry chained through a register,
// results held in a single-entry output register with valid/ready handshakes.
module addc_seq
    import addc_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int THRES = 80,
    parameter int LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_o,
    output logic             out_last,
    output logic             out_cout,
    output logic             busy
);

    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LIMBS - 1);

    addc_state_e      state_reg, state_next;
    addc_op_e         op_reg, op_next;
    logic [IDXW-1:0]  idx_reg, idx_next;
    logic             carry_reg, carry_next;
    logic [WIDTH-1:0] out_o_reg, out_o_next;
    logic             out_last_reg, out_last_next;
    logic             out_cout_reg, out_cout_next;
    logic             out_valid_reg, out_valid_next;

    logic             accept;
    logic             first_limb;
    logic             is_last;
    logic             sub_eff;
    logic             add_cin;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign in_ready   = !out_valid_reg || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_limb = (state_reg == IDLE);
    assign is_last    = (idx_reg == LAST_IDX);

    // Subtraction is A + ~B + 1; the +1 rides in as carry-in on limb 0 only.
    assign sub_eff = first_limb ? in_sub : (op_reg == SUB);
    assign add_b   = sub_eff ? ~in_b : in_b;
    assign add_cin = first_limb ? in_sub : carry_reg;

    addcpred #(
        .WIDTH (WIDTH),
        .THRES (THRES)
    ) u_add (
        .a    (in_a),
        .b    (add_b),
        .cin  (add_cin),
        .o    (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        idx_next       = idx_reg;
        carry_next     = carry_reg;
        out_o_next     = out_o_reg;
        out_last_next  = out_last_reg;
        out_cout_next  = out_cout_reg;
        out_valid_next = out_valid_reg && !out_ready;

        if (accept) begin
            out_valid_next = 1'b1;
            out_o_next     = add_sum;
            out_last_next  = is_last;
            out_cout_next  = is_last ? add_cout : 1'b0;
            carry_next     = add_cout;
            if (first_limb) begin
                op_next = in_sub ? SUB : ADD;
            end
            if (is_last) begin
                state_next = IDLE;
                idx_next   = '0;
                carry_next = 1'b0;
            end else begin
                state_next = BUSY;
                idx_next   = idx_reg + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= ADD;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            out_o_reg     <= '0;
            out_last_reg  <= 1'b0;
            out_cout_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            idx_reg       <= idx_next;
            carry_reg     <= carry_next;
            out_o_reg     <= out_o_next;
            out_last_reg  <= out_last_next;
            out_cout_reg  <= out_cout_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_o     = out_o_reg;
    assign out_last  = out_last_reg;
    assign out_cout  = out_cout_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == BUSY);

endmodule

// File: doc/addc_seq.md
# addc_seq

Multi-cycle wide-integer add/subtract sequencer built around one `addcpred` instance. It accepts operands as a stream of WIDTH-bit limbs, least-significant first, and chains the carry through a register between limbs. It emits result limbs with a last flag and the final carry-out. It sits in the mul_unit as the shared accumulation/adjust adder for operands wider than one datapath word.

## Interface
- `WIDTH`, 256: limb width; passed to `addcpred`.
- `THRES`, 80: passed to `addcpred` unchanged.
- `LIMBS`, 4: limbs per operation, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  limb offered.
- `in_ready`  out  1  limb accepted when `in_valid && in_ready`.
- `in_a`  in  WIDTH  operand A limb.
- `in_b`  in  WIDTH  operand B limb.
- `in_sub`  in  1  0 = A+B, 1 = A−B; sampled on limb 0 only.
- `out_valid`  out  1  result limb held.
- `out_ready`  in  1  consumer accepts.
- `out_o`  out  WIDTH  result limb.
- `out_last`  out  1  limb is index LIMBS−1.
- `out_cout`  out  1  final carry; meaningful only with `out_last`. For SUB, 1 = no borrow.
- `busy`  out  1  operation in progress (state BUSY).

## Operation
- States:
  - IDLE: next accepted limb is limb 0.
  - BUSY: limbs 1..LIMBS−1 pending.
- Registers:
  - `op_sub`: latched from `in_sub` on limb 0.
  - `carry`: carry to the next limb.
  - `idx`: counter, width max(1, $clog2(LIMBS)).
  - Output register: `out_o`, `out_last`, `out_cout`, `out_valid`.
- Adder inputs on accept:
  - b' = sub ? ~in_b : in_b, where sub = `in_sub` on limb 0, else `op_sub`.
  - cin = sub on limb 0; cin = `carry` otherwise.
- On accept:
  - Output register ← adder sum.
  - `carry` ← adder cout.
  - `out_last` = (idx == LIMBS−1).
  - `out_cout` = adder cout when last, else 0.
- Transitions:
  - Limb 0 with LIMBS>1: IDLE→BUSY, idx←1.
  - Last limb: →IDLE, idx←0, carry←0.
  - LIMBS=1: every limb is last and the state stays IDLE.
- `in_sub` is ignored on limbs 1..LIMBS−1.
- No carry leaks across operations.
- Arithmetic is modulo 2^(WIDTH·LIMBS). No overflow flag; `out_cout` is the only width-extension bit.
- `busy` = (state == BUSY).

## Timing
- Reset values:
  - `out_valid`=0, `out_o`=0, `out_last`=0, `out_cout`=0.
  - `busy`=0, state IDLE, idx=0, carry=0, op_sub=0.
  - `in_ready`=1 once reset is released.
- Latency: a limb accepted at edge N appears with `out_valid` after edge N. One limb per cycle throughput under no backpressure.
- `in_ready` = !out_valid || out_ready. This is a combinational pass-through of `out_ready`, a single-entry pipeline register.
- Simultaneous drain and accept: the output register is overwritten in the same cycle and `out_valid` stays 1.
- Under `out_ready`=0, `out_o`, `out_last` and `out_cout` hold stable and no limb is accepted.
- Input stall mid-operation (`in_valid`=0 in BUSY): state, idx and carry hold indefinitely.
- Reset asserted mid-operation:
  - Partial operation is discarded.
  - Pending output is dropped.
  - The first limb after release is limb 0.
- The combinational path is in_a/in_b → `addcpred` → output register within one cycle. The adder depth is governed by THRES.

## Structure
- Package `addc_pkg`: `addc_state_e` {IDLE, BUSY}, `addc_op_e` {ADD=0, SUB=1}.
- Single sub-module: one `addcpred` #(WIDTH, THRES) instance. No other hierarchy; FSM, counter and output register stay in `addc_seq`.

## Test plan
Bench: WIDTH=8, THRES=4 (forces split path), LIMBS=4, limb 0 first.
- ADD ripple: A=0x00FFFFFF, B=0x00000001 → limbs 00,00,00,01. `out_last` on 4th limb, `out_cout`=0.
- SUB borrow: A=0x00000000, B=0x00000001 → FF,FF,FF,FF, `out_cout`=0. Then A=5, B=3 → 02,00,00,00, `out_cout`=1.
- Carry out / no leak: ADD 0xFFFFFFFF+0x00000001 → 00,00,00,00, `out_cout`=1. Immediately follow with ADD 1+1 → 02,00,00,00, `out_cout`=0.
- Backpressure: `out_ready`=0 for 3 cycles mid-operation → `in_ready`=0 and `out_o` stable for 3 cycles. Stream resumes with correct results and no lost or duplicated limbs.
- `in_sub` toggled on limbs 1–3 of an ADD → result identical to pure ADD.
- Reset after 2 limbs accepted → all outputs 0 and `busy`=0. Next operation ADD 7+1 gives 08,00,00,00 with `out_last` on its 4th limb.
